// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed 35-cycle occupancy, results presented in register-file write-port form.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// PREP  | take absolute values of signed operands, record result sign
// ITER  | one multiplier bit / quotient bit per cycle, ITERS cycles
// FIX   | sign-correct, select result word, apply div-by-zero/overflow cases
// DONE  | write strobe high for one cycle (suppressed for x0)
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int ITERS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] data_a,
   input  logic [XLEN-1:0] data_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic [XLEN-1:0] data_d,
   output logic [4:0]      reg_addres_d,
   output logic            ctrl_wb_enable
);

   localparam int CW = $clog2(ITERS);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t          state;
   logic [2:0]      op_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic [2*XLEN-1:0] acc;
   logic [CW-1:0]   cnt;
   logic            neg_res;
   logic            div_zero;
   logic            div_ovf;

   logic            is_div;
   logic            a_signed;
   logic            b_signed;
   logic            sa;
   logic            sb;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic            neg_next;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   trial;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] fix_res;

   always_comb begin
      is_div   = op_q[2];
      a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                 (op_q == OP_DIV)  || (op_q == OP_REM);
      b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
      sa       = a_signed & a_q[XLEN-1];
      sb       = b_signed & b_q[XLEN-1];
      a_abs    = sa ? -a_q : a_q;
      b_abs    = sb ? -b_q : b_q;
      neg_next = 1'b0;
      case (op_q)
         OP_MUL, OP_MULH, OP_MULHSU, OP_DIV: neg_next = sa ^ sb;
         OP_REM:                             neg_next = sa;
         default:                            neg_next = 1'b0;
      endcase

      // multiply: product accumulates in the top half and shifts right
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (b_q[0] ? a_q : '0)};
      // divide: acc = {remainder, quotient}, dividend bits shift out of a_q
      trial   = {acc[2*XLEN-1:XLEN], a_q[XLEN-1]} - {1'b0, b_q};

      prod = neg_res ? -acc : acc;
      quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = neg_res ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

      fix_res = '0;
      case (op_q)
         OP_MUL:                     fix_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU: begin
            if (div_zero)
               fix_res = '1;
            else if (div_ovf)
               fix_res = {1'b1, {(XLEN-1){1'b0}}};
            else
               fix_res = quo;
         end
         default: begin
            // remainder by zero leaves |dividend| in the remainder, re-signed above
            if (div_ovf)
               fix_res = '0;
            else
               fix_res = rem;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         op_q           <= '0;
         rd_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         acc            <= '0;
         cnt            <= '0;
         neg_res        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         busy           <= 1'b0;
         data_d         <= '0;
         reg_addres_d   <= '0;
         ctrl_wb_enable <= 1'b0;
      end else begin
         ctrl_wb_enable <= 1'b0;
         if (flush && (state != S_IDLE)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && !flush) begin
                     op_q  <= op;
                     rd_q  <= rd_in;
                     a_q   <= data_a;
                     b_q   <= data_b;
                     busy  <= 1'b1;
                     state <= S_PREP;
                  end
               end
               S_PREP: begin
                  a_q      <= a_abs;
                  b_q      <= b_abs;
                  neg_res  <= neg_next;
                  div_zero <= (b_q == '0);
                  div_ovf  <= ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                              (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
                  acc      <= '0;
                  cnt      <= '0;
                  state    <= S_ITER;
               end
               S_ITER: begin
                  if (is_div) begin
                     a_q <= {a_q[XLEN-2:0], 1'b0};
                     if (!trial[XLEN])
                        acc <= {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                     else
                        acc <= {acc[2*XLEN-2:XLEN], a_q[XLEN-1], acc[XLEN-2:0], 1'b0};
                  end else begin
                     b_q <= {1'b0, b_q[XLEN-1:1]};
                     acc <= {mul_sum, acc[XLEN-1:1]};
                  end
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST)
                     state <= S_FIX;
               end
               S_FIX: begin
                  data_d         <= fix_res;
                  reg_addres_d   <= rd_q;
                  ctrl_wb_enable <= (rd_q != 5'd0);
                  state          <= S_DONE;
               end
               S_DONE: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
